// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer scheduler.
//   spi_state_e : scheduler FSM states
//   spi_mode_e  : SPI mode encodings MODE0..MODE3
//   WORD_W      : default SPI word width
package spi_pkg;

  localparam int unsigned WORD_W = 18;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPulse,
    StWaitStart,
    StWaitDone,
    StStore
  } spi_state_e;

endpackage

// File: rtl/spi_xfer_sched_if.sv
// Bus bundle between the scheduler and its surroundings.
//   wr_*        : TX word push handshake plus per-transfer cfg_speed/cfg_mode
//   rd_*        : RX word pop handshake
//   tx_enable, data_in, clock_speed, spi_mode : drive side of the SPI master
//   master_out, mrx_data_valid                : return side of the SPI master
//   busy, err_timeout, err_clr                : status and sticky error clear
// Modport slave is the scheduler view; master is the environment view.
interface spi_xfer_sched_if
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) ();

  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       cfg_speed;
  logic [1:0]       cfg_mode;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic             tx_enable;
  logic [WIDTH-1:0] data_in;
  logic [1:0]       clock_speed;
  logic [1:0]       spi_mode;
  logic [WIDTH-1:0] master_out;
  logic             mrx_data_valid;
  logic             busy;
  logic             err_timeout;
  logic             err_clr;

  modport slave (
    input  wr_valid, wr_data, cfg_speed, cfg_mode, rd_ready, master_out, mrx_data_valid,
           err_clr,
    output wr_ready, rd_valid, rd_data, tx_enable, data_in, clock_speed, spi_mode, busy,
           err_timeout
  );

  modport master (
    output wr_valid, wr_data, cfg_speed, cfg_mode, rd_ready, master_out, mrx_data_valid,
           err_clr,
    input  wr_ready, rd_valid, rd_data, tx_enable, data_in, clock_speed, spi_mode, busy,
           err_timeout
  );

endinterface

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word fall-through FIFO.
//   i_clk, i_rst      : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data    : write request and data; ignored when full
//   i_pop             : read request; ignored when empty
//   o_data            : head word, valid whenever o_empty is low
//   o_full, o_empty   : occupancy flags
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];

  // Gating by the flags makes push-on-full and pop-on-empty no-ops even when
  // both requests arrive together.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// SPI transfer scheduler: pulls words from a TX FIFO, launches one SPI master
// transfer per word and stores the returned word in an RX FIFO.
//   sys_clock, reset : clock and synchronous active-high reset
//   bus (slave)      : push/pop handshakes, SPI master drive/return, status
// A transfer only starts when the RX FIFO has room, so a returned word is
// never dropped for lack of space.
module spi_xfer_sched
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH    = WORD_W,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned START_TO = 16,
  parameter int unsigned DONE_TO  = 1023
) (
  input logic             sys_clock,
  input logic             reset,
  spi_xfer_sched_if.slave bus
);

  localparam int unsigned CNT_MAX = (START_TO > DONE_TO) ? START_TO : DONE_TO;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  spi_state_e       r_state;
  spi_state_e       w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tx_enable;
  logic [WIDTH-1:0] r_data_in;
  logic [1:0]       r_clock_speed;
  spi_mode_e        r_spi_mode;
  logic             r_err;

  logic             w_tx_full;
  logic             w_tx_empty;
  logic [WIDTH-1:0] w_tx_head;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic             w_tx_pop;
  logic             w_rx_push;
  logic             w_timeout;

  spi_sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_tx_fifo (
    .i_clk  (sys_clock),
    .i_rst  (reset),
    .i_push (bus.wr_valid),
    .i_data (bus.wr_data),
    .o_full (w_tx_full),
    .i_pop  (w_tx_pop),
    .o_data (w_tx_head),
    .o_empty(w_tx_empty)
  );

  spi_sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_rx_fifo (
    .i_clk  (sys_clock),
    .i_rst  (reset),
    .i_push (w_rx_push),
    .i_data (bus.master_out),
    .o_full (w_rx_full),
    .i_pop  (bus.rd_ready),
    .o_data (bus.rd_data),
    .o_empty(w_rx_empty)
  );

  always_comb begin
    w_state_d = r_state;
    w_tx_pop  = 1'b0;
    w_rx_push = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_tx_empty && !w_rx_full) begin
          w_state_d = StLoad;
        end
      end
      StLoad: begin
        w_tx_pop  = 1'b1;
        w_state_d = StPulse;
      end
      StPulse: begin
        w_state_d = StWaitStart;
      end
      StWaitStart: begin
        // The master drops its completion flag when the transfer begins.
        if (!bus.mrx_data_valid) begin
          w_state_d = StWaitDone;
        end else if (r_cnt == CNT_W'(START_TO - 1)) begin
          w_state_d = StIdle;
          w_timeout = 1'b1;
        end
      end
      StWaitDone: begin
        if (bus.mrx_data_valid) begin
          w_state_d = StStore;
        end else if (r_cnt == CNT_W'(DONE_TO - 1)) begin
          w_state_d = StIdle;
          w_timeout = 1'b1;
        end
      end
      StStore: begin
        w_rx_push = 1'b1;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_tx_enable   <= 1'b0;
      r_data_in     <= '1;
      r_clock_speed <= '0;
      r_spi_mode    <= MODE0;
      r_err         <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      // High exactly while the FSM sits in PULSE, but from a flop.
      r_tx_enable <= (w_state_d == StPulse);

      // Counter restarts on every state change; it only runs in the wait states.
      if (w_state_d != r_state) begin
        r_cnt <= '0;
      end else if (r_state == StWaitStart || r_state == StWaitDone) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // Word and configuration are frozen for the whole transfer.
      if (w_tx_pop) begin
        r_data_in     <= w_tx_head;
        r_clock_speed <= bus.cfg_speed;
        r_spi_mode    <= spi_mode_e'(bus.cfg_mode);
      end

      // A timeout in the same cycle as err_clr must leave the flag set.
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.wr_ready    = ~w_tx_full;
  assign bus.rd_valid    = ~w_rx_empty;
  assign bus.tx_enable   = r_tx_enable;
  assign bus.data_in     = r_data_in;
  assign bus.clock_speed = r_clock_speed;
  assign bus.spi_mode    = r_spi_mode;
  assign bus.busy        = (r_state != StIdle);
  assign bus.err_timeout = r_err;

endmodule

// File: doc/spi_xfer_sched.md
SPI_XFER_SCHED -- requirements
Module: spi_xfer_sched

Interface
REQ-001 Parameter WIDTH, default 18, SHALL set the SPI word width for the data ports and both FIFOs.
REQ-002 Parameter DEPTH, default 4, SHALL set the TX and RX FIFO depth; it must be a power of two and at least 2.
REQ-003 Parameter START_TO, default 16, SHALL set the maximum number of cycles spent in WAIT_START.
REQ-004 Parameter DONE_TO, default 1023, SHALL set the maximum number of cycles spent in WAIT_DONE.
REQ-005 sys_clock  in  1  SHALL be the single clock; every flop is on its rising edge.
REQ-006 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-007 wr_valid / wr_ready  in/out  1/1  SHALL be the TX word push handshake.
REQ-008 wr_data  in  WIDTH  SHALL carry the word to transmit, LSB first on the wire.
REQ-009 cfg_speed / cfg_mode  in  2/2  SHALL carry the clock-speed select and SPI mode; both are sampled per transfer.
REQ-010 rd_valid / rd_ready  out/in  1/1  SHALL be the RX word pop handshake.
REQ-011 rd_data  out  WIDTH  SHALL present the word received from the slave.
REQ-012 tx_enable  out  1  SHALL be the transfer-start pulse to the SPI master.
REQ-013 data_in  out  WIDTH  SHALL drive the word to the SPI master.
REQ-014 clock_speed / spi_mode  out  2/2  SHALL drive the latched configuration to the SPI master.
REQ-015 master_out / mrx_data_valid  in  WIDTH/1  SHALL be the received word and completion flag from the SPI master.
REQ-016 busy  out  1  SHALL be high in every state except IDLE.
REQ-017 err_timeout  out  1  SHALL be a sticky timeout flag.
REQ-018 err_clr  in  1  SHALL clear err_timeout.

Function
REQ-019 The TX and RX FIFOs SHALL be synchronous, first-word fall-through, with push on valid&ready and pop on valid&ready.
REQ-020 wr_ready SHALL be !tx_full; rd_valid SHALL be !rx_empty.
REQ-021 A simultaneous push and pop on a full or empty FIFO SHALL be handled per REQ-020 (no write when full, no read when empty); pointers SHALL wrap modulo DEPTH.
REQ-022 The FSM SHALL have the states IDLE, LOAD, PULSE, WAIT_START, WAIT_DONE and STORE.
REQ-023 IDLE -> LOAD SHALL occur when the TX FIFO is non-empty and the RX FIFO is not full; no transfer SHALL start without RX space.
REQ-024 In LOAD the block SHALL pop the TX head into the data_in register and latch cfg_speed into clock_speed and cfg_mode into spi_mode; tx_enable SHALL be 0 during LOAD.
REQ-025 In PULSE, tx_enable SHALL be 1 for exactly one cycle; tx_enable SHALL be a registered output and 0 in every other state.
REQ-026 The rising edge of tx_enable SHALL therefore occur 2 cycles after IDLE sees a ready word.
REQ-027 WAIT_START -> WAIT_DONE SHALL occur when mrx_data_valid==0, which marks transfer start.
REQ-028 WAIT_DONE -> STORE SHALL occur when mrx_data_valid==1; in STORE master_out SHALL be pushed to the RX FIFO for one cycle, then the FSM SHALL return to IDLE.
REQ-029 data_in, clock_speed and spi_mode SHALL stay stable from LOAD until the FSM leaves WAIT_DONE.
REQ-030 A cycle counter SHALL reset on every state entry.
REQ-031 If the counter reaches START_TO in WAIT_START, or DONE_TO in WAIT_DONE, the FSM SHALL go to IDLE, set err_timeout and discard the word, with no RX push.
REQ-032 err_clr SHALL clear err_timeout; if a timeout occurs in the same cycle as err_clr, the set SHALL win.
REQ-033 Back-to-back words SHALL produce consecutive transfers with at least one IDLE cycle between STORE and the next LOAD.
REQ-034 When rd_ready is held 0 and the RX FIFO fills, the FSM SHALL hold in IDLE and TX words SHALL stay queued.

Reset
REQ-035 reset SHALL put the FSM in IDLE and empty both FIFOs.
REQ-036 Output reset values SHALL be: tx_enable=0, data_in all ones, clock_speed=0, spi_mode=0, busy=0, err_timeout=0, wr_ready=1, rd_valid=0.
REQ-037 A reset asserted mid-transfer SHALL abort the transfer immediately, and no RX push SHALL occur.

Structure
REQ-038 Package spi_pkg SHALL hold the FSM state enum, the WORD_W=18 constant, and the MODE0..MODE3 constants.
REQ-039 A single sub-module, spi_sync_fifo (parameters WIDTH and DEPTH), SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-040 Push 18'h2A5A5 with mode 00 and speed 01, and use a slave model that echoes the word: expect tx_enable high for 1 cycle 2 cycles after the push, then rd_data=18'h2A5A5 and busy=0 after STORE.
REQ-041 Push 4 words back-to-back with rd_ready=0: expect 4 transfers, rx_full, wr_ready=1, and a 5th queued word that does not launch until one RX pop occurs.
REQ-042 Hold mrx_data_valid=1 after PULSE: expect err_timeout=1 after 16 cycles, FSM in IDLE, and no RX word; then err_clr -> err_timeout=0.
REQ-043 Assert reset during WAIT_DONE: expect IDLE, tx_enable=0, rd_valid=0, and empty FIFOs on the next cycle.
REQ-044 Push 5 words into a 4-deep TX FIFO while no transfer is running: expect wr_ready=0 on the 5th word and no overwrite.
REQ-045 Change cfg_mode from 00 to 11 mid-transfer: expect spi_mode to remain 00 until the next LOAD.
